pipe_sched_ctrl: RTL and testbench

PIPE_SCHED_CTRL -- requirements
Module: pipe_sched_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 9 +
 rtl/pipe_sched_ctrl_md_timer.sv | 26 ++
 rtl/pipe_sched_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_sched_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM encoding and default muldiv latencies for the pipeline scheduler
package pipe_ctrl_pkg;

    typedef enum logic {RUN, MDWAIT} state_t;

    localparam int MULT_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF  = 32;

endpackage

// File: rtl/pipe_sched_ctrl_md_timer.sv
// md_timer: muldiv latency down-counter, done pulses on the last busy cycle
module md_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         abort,
    output logic         busy,
    output logic         done
);

    logic [W-1:0] cnt_q;

    // Load on start, clear on abort, otherwise count down to zero
    always_ff @(posedge clk) begin
        if (rst || abort) cnt_q <= '0;
        else if (load) cnt_q <= load_val;
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end

    assign busy = cnt_q != '0;
    assign done = cnt_q == W'(1);

endmodule

// File: rtl/pipe_sched_ctrl.sv
// pipe_sched_ctrl: hazard detection, flush/redirect and muldiv scheduling for a MIPS-style pipeline
module pipe_sched_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        id_muldiv,
    input  logic        id_is_div,
    input  logic        id_hilo_rd,
    input  logic        id_branch_taken,
    input  logic        id_eret,
    input  logic        exc_req,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        pc_sel_exc,
    output logic        pc_sel_epc,
    output logic        md_start,
    output logic        md_abort,
    output logic        hilo_we,
    output logic        md_busy,
    output logic [15:0] stall_cnt
);

    localparam int CW = $clog2((DIV_CYCLES > MULT_CYCLES ? DIV_CYCLES : MULT_CYCLES) + 1);

    state_t        state_q, state_d;
    logic [15:0]   stall_cnt_q;
    logic          t_busy, t_done;
    logic          load_use, hilo_haz, stall;
    logic [CW-1:0] md_len;

    assign load_use = ex_memread && ex_rt != 5'd0 &&
                      ((id_uses_rs && ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
    assign hilo_haz = state_q == MDWAIT && (id_muldiv || id_hilo_rd);
    assign stall    = !exc_req && (load_use || hilo_haz);
    assign md_len   = id_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

    md_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (md_start),
        .load_val (md_len),
        .abort    (md_abort),
        .busy     (t_busy),
        .done     (t_done)
    );

    // Priority-ordered control outputs and next state; everything forced low during reset
    always_comb begin
        state_d     = state_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_sel_exc  = 1'b0;
        pc_sel_epc  = 1'b0;
        md_start    = 1'b0;
        md_abort    = 1'b0;
        hilo_we     = 1'b0;
        md_busy     = 1'b0;
        stall_cnt   = 16'd0;
        if (!rst) begin
            pc_stall    = stall;
            ifid_stall  = stall;
            idex_flush  = exc_req || stall;
            exmem_flush = exc_req;
            pc_sel_exc  = exc_req;
            ifid_flush  = exc_req || (!stall && (id_branch_taken || id_eret));
            pc_sel_epc  = !exc_req && !stall && id_eret;
            md_start    = state_q == RUN && id_muldiv && !exc_req && !stall &&
                          !id_branch_taken && !id_eret;
            hilo_we     = t_done;
            md_abort    = state_q == MDWAIT && exc_req && !t_done;
            md_busy     = t_busy;
            stall_cnt   = stall_cnt_q;
            state_d     = state_q == RUN ? (md_start ? MDWAIT : RUN)
                                         : ((t_done || exc_req) ? RUN : MDWAIT);
        end
    end

    // State register and saturating count of PC-stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (pc_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_sched_ctrl.sv
// tb_pipe_sched_ctrl: directed scoreboard bench for pipe_sched_ctrl
module tb_pipe_sched_ctrl;

    localparam logic [10:0] B_PS = 11'b10000000000;
    localparam logic [10:0] B_IS = 11'b01000000000;
    localparam logic [10:0] B_IF = 11'b00100000000;
    localparam logic [10:0] B_IX = 11'b00010000000;
    localparam logic [10:0] B_EM = 11'b00001000000;
    localparam logic [10:0] B_PX = 11'b00000100000;
    localparam logic [10:0] B_PE = 11'b00000010000;
    localparam logic [10:0] B_MS = 11'b00000001000;
    localparam logic [10:0] B_MA = 11'b00000000100;
    localparam logic [10:0] B_HW = 11'b00000000010;
    localparam logic [10:0] B_MB = 11'b00000000001;
    localparam logic [10:0] STL  = B_PS | B_IS | B_IX;
    localparam logic [10:0] EXC  = B_IF | B_IX | B_EM | B_PX;

    typedef struct {
        string       nm;
        logic [10:0] bits;
        logic [15:0] sc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, ex_memread, id_muldiv, id_is_div;
    logic        id_hilo_rd, id_branch_taken, id_eret, exc_req;
    logic        pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush;
    logic        pc_sel_exc, pc_sel_epc, md_start, md_abort, hilo_we, md_busy;
    logic [15:0] stall_cnt;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    pipe_sched_ctrl dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .id_muldiv(id_muldiv),
        .id_is_div(id_is_div), .id_hilo_rd(id_hilo_rd),
        .id_branch_taken(id_branch_taken), .id_eret(id_eret), .exc_req(exc_req),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .pc_sel_exc(pc_sel_exc), .pc_sel_epc(pc_sel_epc), .md_start(md_start),
        .md_abort(md_abort), .hilo_we(hilo_we), .md_busy(md_busy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: compare every queued expectation against the DUT mid-cycle
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [10:0] act;
            e   = q.pop_front();
            act = {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush,
                   pc_sel_exc, pc_sel_epc, md_start, md_abort, hilo_we, md_busy};
            checks++;
            if (act !== e.bits || stall_cnt !== e.sc) begin
                fails++;
                $display("FAIL %s: got outs=%b stall_cnt=%0d, want outs=%b stall_cnt=%0d",
                         e.nm, act, stall_cnt, e.bits, e.sc);
            end
        end
    end

    task automatic clr();
        id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_memread = 0; id_muldiv = 0; id_is_div = 0; id_hilo_rd = 0;
        id_branch_taken = 0; id_eret = 0; exc_req = 0;
    endtask

    task automatic cyc(input string nm, input logic [10:0] bits, input logic [15:0] sc);
        exp_t e;
        e.nm = nm; e.bits = bits; e.sc = sc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr();
        rst = 1;
        id_muldiv = 1; id_hilo_rd = 1; exc_req = 1;
        cyc("reset_outs", 11'd0, 16'd0);
        rst = 0;
        clr();
    endtask

    initial begin
        clr();
        rst = 1;
        @(posedge clk);
        #1;
        do_reset();
        ex_memread = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1;
        cyc("load_use_rs", STL, 16'd0);
        ex_rt = 0; id_rs = 0;
        cyc("load_use_r0", 11'd0, 16'd1);
        ex_rt = 7; id_rt = 7; id_uses_rs = 0; id_uses_rt = 1;
        cyc("load_use_rt", STL, 16'd1);
        id_uses_rt = 0;
        cyc("no_use_flag", 11'd0, 16'd2);

        do_reset();
        id_muldiv = 1;
        cyc("mult_start", B_MS, 16'd0);
        clr();
        for (int i = 1; i <= 3; i++) cyc("mult_busy", B_MB, 16'd0);
        cyc("mult_hilo_we", B_MB | B_HW, 16'd0);
        cyc("mult_idle", 11'd0, 16'd0);
        id_muldiv = 1; id_is_div = 1;
        cyc("div_start", B_MS, 16'd0);
        clr();
        for (int i = 1; i <= 31; i++) cyc("div_busy", B_MB, 16'd0);
        cyc("div_hilo_we", B_MB | B_HW, 16'd0);
        cyc("div_idle", 11'd0, 16'd0);

        do_reset();
        id_muldiv = 1;
        cyc("mfhi_mstart", B_MS, 16'd0);
        clr();
        id_hilo_rd = 1;
        for (int i = 0; i < 3; i++) cyc("mfhi_stall", STL | B_MB, 16'(i));
        cyc("mfhi_stall_we", STL | B_MB | B_HW, 16'd3);
        cyc("mfhi_release", 11'd0, 16'd4);
        clr();
        cyc("mfhi_after", 11'd0, 16'd4);

        do_reset();
        id_muldiv = 1; id_is_div = 1;
        cyc("exc_div_start", B_MS, 16'd0);
        clr();
        for (int i = 1; i <= 9; i++) cyc("exc_div_busy", B_MB, 16'd0);
        exc_req = 1;
        cyc("exc_abort", EXC | B_MA | B_MB, 16'd0);
        clr();
        for (int i = 0; i < 25; i++) cyc("exc_no_hilo", 11'd0, 16'd0);
        id_muldiv = 1;
        cyc("exc_mult_start", B_MS, 16'd0);
        clr();
        for (int i = 1; i <= 3; i++) cyc("exc_mult_busy", B_MB, 16'd0);
        exc_req = 1;
        cyc("exc_last_cycle", EXC | B_MB | B_HW, 16'd0);
        id_muldiv = 1; ex_memread = 1; ex_rt = 3; id_rs = 3; id_uses_rs = 1;
        cyc("exc_over_lu_md", EXC, 16'd0);
        clr();
        cyc("exc_after", 11'd0, 16'd0);

        do_reset();
        ex_memread = 1; ex_rt = 9; id_rt = 9; id_uses_rt = 1; id_branch_taken = 1;
        cyc("br_in_stall", STL, 16'd0);
        ex_memread = 0;
        cyc("br_flush", B_IF, 16'd1);
        clr();
        id_eret = 1;
        cyc("eret_flush", B_IF | B_PE, 16'd1);
        clr();

        do_reset();
        id_muldiv = 1; id_is_div = 1;
        cyc("rst_div_start", B_MS, 16'd0);
        clr();
        id_hilo_rd = 1;
        for (int i = 0; i < 3; i++) cyc("rst_div_stall", STL | B_MB, 16'(i));
        rst = 1;
        cyc("rst_mid_md", 11'd0, 16'd0);
        rst = 0;
        clr();
        for (int i = 0; i < 35; i++) cyc("rst_no_hilo", 11'd0, 16'd0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
